// File: rtl/regwb_arbiter.sv
`default_nettype none
// ============================================================================
// regwb_arbiter : register-file write-port arbiter (pipeline priority, MDU FIFO,
//                 busy scoreboard, starvation stall). Option: REGWB_BYPASS_EN
// Revision      : 1.0
// ============================================================================
module regwb_arbiter #(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pipe_we,
  input  logic [4:0]               pipe_waddr,
  input  logic [31:0]              pipe_wdata,
  input  logic                     mdu_valid,
  output logic                     mdu_ready,
  input  logic [4:0]               mdu_waddr,
  input  logic [31:0]              mdu_wdata,
  input  logic                     iss_valid,
  input  logic [4:0]               iss_rd,
  input  logic [4:0]               chk_rs1,
  input  logic [4:0]               chk_rs2,
  input  logic [4:0]               chk_rd,
  output logic                     chk_hazard,
  output logic                     pipe_stall,
  output logic                     regwrite,
  output logic [4:0]               waddr,
  output logic [31:0]              wdata,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] C_DEPTH    = CW'(DEPTH);
  localparam logic [WW-1:0] C_MAX_WAIT = WW'(MAX_WAIT);

  logic [4:0]    r_fa [DEPTH];
  logic [31:0]   r_fd [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [CW-1:0] r_count;
  logic [WW-1:0] r_wait;
  logic [31:0]   r_busy;

  logic          w_pipe_req;
  logic          w_pop;
  logic          w_enq;
  logic [4:0]    w_head_addr;
  logic [31:0]   w_head_data;
  logic [31:0]   w_set;
  logic [31:0]   w_clr;
  logic [31:0]   w_busy_nxt;
  logic [31:0]   w_busy_chk;

  assign pipe_stall  = !rst && (r_wait == C_MAX_WAIT);
  assign w_pipe_req  = !rst && pipe_we && (pipe_waddr != 5'd0) && !pipe_stall;
  assign w_pop       = !rst && !w_pipe_req && (r_count != '0);
  assign mdu_ready   = !rst && (r_count < C_DEPTH);
  // x0 results are acknowledged but never take a FIFO slot
  assign w_enq       = mdu_valid && mdu_ready && (mdu_waddr != 5'd0);
  assign w_head_addr = r_fa[r_rp];
  assign w_head_data = r_fd[r_rp];
  assign fifo_count  = r_count;

  always_comb begin
    regwrite = 1'b0;
    waddr    = 5'd0;
    wdata    = 32'd0;
    if (w_pipe_req) begin
      regwrite = 1'b1;
      waddr    = pipe_waddr;
      wdata    = pipe_wdata;
    end else if (w_pop) begin
      regwrite = 1'b1;
      waddr    = w_head_addr;
      wdata    = w_head_data;
    end
  end

  assign w_set      = (!rst && iss_valid && (iss_rd != 5'd0)) ? (32'd1 << iss_rd) : 32'd0;
  assign w_clr      = w_pop ? (32'd1 << w_head_addr) : 32'd0;
  // set is applied after clear so a same-cycle re-issue keeps the register busy
  assign w_busy_nxt = ((r_busy & ~w_clr) | w_set) & ~32'd1;

`ifdef REGWB_BYPASS_EN
  assign w_busy_chk = r_busy & ~w_clr;
`else
  assign w_busy_chk = r_busy;
`endif

  assign chk_hazard = !rst && (w_busy_chk[chk_rs1] | w_busy_chk[chk_rs2] | w_busy_chk[chk_rd]);

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_fa[r_wp] <= mdu_waddr;
      r_fd[r_wp] <= mdu_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      r_wait  <= '0;
      r_busy  <= '0;
    end else begin
      if (w_enq) r_wp <= r_wp + AW'(1);
      if (w_pop) r_rp <= r_rp + AW'(1);
      r_count <= r_count + CW'(w_enq) - CW'(w_pop);
      if (w_pop || (r_count == '0)) r_wait <= '0;
      else if (r_wait != C_MAX_WAIT) r_wait <= r_wait + WW'(1);
      r_busy <= w_busy_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regwb_arbiter.sv
`default_nettype none
// ============================================================================
// tb_regwb_arbiter : directed scenarios plus randomized traffic vs a queue model
// Revision         : 1.0
// ============================================================================
module tb_regwb_arbiter;

  localparam int DEPTH    = 4;
  localparam int MAX_WAIT = 8;
  localparam int CW       = $clog2(DEPTH) + 1;
`ifdef REGWB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk, rst;
  logic pipe_we, mdu_valid, mdu_ready, iss_valid;
  logic chk_hazard, pipe_stall, regwrite;
  logic [4:0] pipe_waddr, mdu_waddr, iss_rd, chk_rs1, chk_rs2, chk_rd, waddr;
  logic [31:0] pipe_wdata, mdu_wdata, wdata;
  logic [CW-1:0] fifo_count;

  int n_checks = 0;
  int n_err    = 0;

  regwb_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_waddr(mdu_waddr), .mdu_wdata(mdu_wdata),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd), .chk_hazard(chk_hazard),
    .pipe_stall(pipe_stall), .regwrite(regwrite), .waddr(waddr), .wdata(wdata),
    .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: a queue of pending results, a set of busy registers,
  // and a count of how long the oldest result has been passed over
  bit [4:0]  m_qa[$];
  bit [31:0] m_qd[$];
  bit [31:0] m_busy;
  int        m_wait;
  bit        m_pop, m_preq;
  logic exp_rw, exp_ready, exp_stall, exp_haz;
  logic [4:0] exp_wa;
  logic [31:0] exp_wd;
  logic [CW-1:0] exp_cnt;

  function automatic void model_comb();
    logic [4:0] r;
    exp_cnt   = CW'(m_qa.size());
    exp_stall = !rst && (m_wait == MAX_WAIT);
    m_preq    = !rst && pipe_we && (pipe_waddr != 0) && !exp_stall;
    m_pop     = !rst && !m_preq && (m_qa.size() != 0);
    exp_ready = !rst && (m_qa.size() < DEPTH);
    exp_rw = 1'b0; exp_wa = 5'd0; exp_wd = 32'd0;
    if (m_preq) begin
      exp_rw = 1'b1; exp_wa = pipe_waddr; exp_wd = pipe_wdata;
    end else if (m_pop) begin
      exp_rw = 1'b1; exp_wa = m_qa[0]; exp_wd = m_qd[0];
    end
    exp_haz = 1'b0;
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        r = (i == 0) ? chk_rs1 : (i == 1) ? chk_rs2 : chk_rd;
        if (m_busy[r] && !(BYP && m_pop && (r == m_qa[0]))) exp_haz = 1'b1;
      end
    end
  endfunction

  function automatic void model_seq();
    int sz;
    bit [4:0] a;
    if (rst) begin
      m_qa.delete(); m_qd.delete(); m_busy = '0; m_wait = 0;
      return;
    end
    sz = m_qa.size();
    if (m_pop) begin
      a = m_qa.pop_front();
      void'(m_qd.pop_front());
      m_busy[a] = 1'b0;
    end
    if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1'b1;
    if (mdu_valid && exp_ready && mdu_waddr != 0) begin
      m_qa.push_back(mdu_waddr);
      m_qd.push_back(mdu_wdata);
    end
    if (m_pop || sz == 0) m_wait = 0;
    else if (m_wait < MAX_WAIT) m_wait++;
  endfunction

  task automatic adv();
    model_comb();
    @(posedge clk);
    model_seq();
    #1;
  endtask

  task automatic drive_idle();
    pipe_we = 0; pipe_waddr = 0; pipe_wdata = 0;
    mdu_valid = 0; mdu_waddr = 0; mdu_wdata = 0;
    iss_valid = 0; iss_rd = 0;
    chk_rs1 = 0; chk_rs2 = 0; chk_rd = 0;
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1; pipe_we = 1; pipe_waddr = 3; mdu_valid = 1; mdu_waddr = 4;
    iss_valid = 1; iss_rd = 9; chk_rs1 = 9;
    #1;
    n_checks++;
    if ({regwrite, mdu_ready, pipe_stall, chk_hazard} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_outputs: got rw=%b rdy=%b stall=%b haz=%b, expected all 0",
               regwrite, mdu_ready, pipe_stall, chk_hazard);
    end
    adv(); adv();
    rst = 0; drive_idle(); chk_rs1 = 9;
    #1;
    n_checks++;
    if ({fifo_count, mdu_ready, chk_hazard, regwrite} !== {CW'(0), 3'b100}) begin
      n_err++;
      $display("FAIL reset_release: got cnt=%0d rdy=%b haz=%b rw=%b, expected cnt=0 rdy=1 haz=0 rw=0",
               fifo_count, mdu_ready, chk_hazard, regwrite);
    end
    adv();
  endtask

  task automatic test_basic_drain();
    drive_idle(); iss_valid = 1; iss_rd = 5;
    adv();
    drive_idle(); mdu_valid = 1; mdu_waddr = 5; mdu_wdata = 32'hDEADBEEF; chk_rs1 = 5;
    #1;
    n_checks++;
    if ({chk_hazard, regwrite} !== 2'b10) begin
      n_err++;
      $display("FAIL drain_push_cycle: got haz=%b rw=%b, expected haz=1 rw=0", chk_hazard, regwrite);
    end
    adv();
    mdu_valid = 0;
    #1;
    n_checks++;
    if ({regwrite, waddr, wdata, chk_hazard} !== {1'b1, 5'd5, 32'hDEADBEEF, !BYP}) begin
      n_err++;
      $display("FAIL drain_write: got rw=%b wa=%0d wd=%h haz=%b, expected rw=1 wa=5 wd=deadbeef haz=%b",
               regwrite, waddr, wdata, chk_hazard, !BYP);
    end
    adv();
    #1;
    n_checks++;
    if ({chk_hazard, regwrite, fifo_count} !== {2'b00, CW'(0)}) begin
      n_err++;
      $display("FAIL drain_clear: got haz=%b rw=%b cnt=%0d, expected 0 0 0", chk_hazard, regwrite, fifo_count);
    end
    adv();
  endtask

  task automatic test_priority();
    logic [4:0] ea [3];
    logic [31:0] ed [3];
    ea = '{5'd10, 5'd11, 5'd0};
    ed = '{32'hA0A0_0001, 32'hB0B0_0002, 32'd0};
    for (int i = 0; i < 3; i++) begin
      drive_idle();
      pipe_we = 1; pipe_waddr = 5'(i + 1); pipe_wdata = 32'h1000 + 32'(i);
      if (i < 2) begin
        mdu_valid = 1; mdu_waddr = ea[i]; mdu_wdata = ed[i];
      end
      #1;
      n_checks++;
      if ({regwrite, waddr, wdata} !== {1'b1, 5'(i + 1), 32'h1000 + 32'(i)}) begin
        n_err++;
        $display("FAIL prio_pipe[%0d]: got rw=%b wa=%0d wd=%h, expected rw=1 wa=%0d wd=%h",
                 i, regwrite, waddr, wdata, i + 1, 32'h1000 + i);
      end
      adv();
    end
    drive_idle();
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if ({regwrite, waddr, wdata, fifo_count} !== {(i < 2), ea[i], ed[i], CW'(2 - i)}) begin
        n_err++;
        $display("FAIL prio_drain[%0d]: got rw=%b wa=%0d wd=%h cnt=%0d, expected rw=%b wa=%0d wd=%h cnt=%0d",
                 i, regwrite, waddr, wdata, fifo_count, i < 2, ea[i], ed[i], 2 - i);
      end
      adv();
    end
  endtask

  task automatic test_starvation();
    drive_idle();
    pipe_we = 1; pipe_waddr = 3; pipe_wdata = 32'h33;
    mdu_valid = 1; mdu_waddr = 12; mdu_wdata = 32'hC0FFEE12;
    adv();
    mdu_valid = 0;
    for (int k = 1; k <= MAX_WAIT; k++) begin
      #1;
      n_checks++;
      if ({pipe_stall, waddr} !== {1'b0, 5'd3}) begin
        n_err++;
        $display("FAIL starve_wait[%0d]: got stall=%b wa=%0d, expected stall=0 wa=3", k, pipe_stall, waddr);
      end
      adv();
    end
    #1;
    n_checks++;
    if ({pipe_stall, regwrite, waddr, wdata} !== {2'b11, 5'd12, 32'hC0FFEE12}) begin
      n_err++;
      $display("FAIL starve_stall: got stall=%b rw=%b wa=%0d wd=%h, expected 1 1 12 c0ffee12",
               pipe_stall, regwrite, waddr, wdata);
    end
    adv();
    #1;
    n_checks++;
    if ({pipe_stall, waddr, fifo_count} !== {1'b0, 5'd3, CW'(0)}) begin
      n_err++;
      $display("FAIL starve_after: got stall=%b wa=%0d cnt=%0d, expected 0 3 0", pipe_stall, waddr, fifo_count);
    end
    adv();
  endtask

  task automatic test_full();
    drive_idle(); pipe_we = 1; pipe_waddr = 4; pipe_wdata = 32'h44;
    for (int i = 0; i < DEPTH; i++) begin
      mdu_valid = 1; mdu_waddr = 5'(13 + i); mdu_wdata = 32'hF000 + 32'(i);
      adv();
    end
    mdu_valid = 0;
    #1;
    n_checks++;
    if ({mdu_ready, fifo_count} !== {1'b0, CW'(DEPTH)}) begin
      n_err++;
      $display("FAIL full_state: got rdy=%b cnt=%0d, expected rdy=0 cnt=%0d", mdu_ready, fifo_count, DEPTH);
    end
    adv();
    pipe_we = 0; mdu_valid = 1; mdu_waddr = 17; mdu_wdata = 32'hBAD;
    #1;
    n_checks++;
    if ({mdu_ready, regwrite, waddr} !== {2'b01, 5'd13}) begin
      n_err++;
      $display("FAIL full_pop_push: got rdy=%b rw=%b wa=%0d, expected rdy=0 rw=1 wa=13", mdu_ready, regwrite, waddr);
    end
    adv();
    mdu_valid = 0; pipe_we = 1;
    #1;
    n_checks++;
    if ({mdu_ready, fifo_count} !== {1'b1, CW'(DEPTH - 1)}) begin
      n_err++;
      $display("FAIL full_after: got rdy=%b cnt=%0d, expected rdy=1 cnt=%0d", mdu_ready, fifo_count, DEPTH - 1);
    end
    adv();
    pipe_we = 0;
    for (int i = 1; i < DEPTH; i++) begin
      #1;
      n_checks++;
      if ({regwrite, waddr, wdata} !== {1'b1, 5'(13 + i), 32'hF000 + 32'(i)}) begin
        n_err++;
        $display("FAIL full_drain[%0d]: got rw=%b wa=%0d wd=%h, expected rw=1 wa=%0d wd=%h",
                 i, regwrite, waddr, wdata, 13 + i, 32'hF000 + i);
      end
      adv();
    end
    #1;
    n_checks++;
    if ({regwrite, fifo_count} !== {1'b0, CW'(0)}) begin
      n_err++;
      $display("FAIL full_empty: got rw=%b cnt=%0d, expected rw=0 cnt=0 (rejected push leaked)", regwrite, fifo_count);
    end
    adv();
  endtask

  task automatic test_same_reg();
    drive_idle(); mdu_valid = 1; mdu_waddr = 7; mdu_wdata = 32'h7777_0001;
    adv();
    drive_idle(); iss_valid = 1; iss_rd = 7;
    #1;
    n_checks++;
    if ({regwrite, waddr} !== {1'b1, 5'd7}) begin
      n_err++;
      $display("FAIL same_pop: got rw=%b wa=%0d, expected rw=1 wa=7", regwrite, waddr);
    end
    adv();
    drive_idle(); chk_rs1 = 7; mdu_valid = 1; mdu_waddr = 7; mdu_wdata = 32'h7777_0002;
    #1;
    n_checks++;
    if (chk_hazard !== 1'b1) begin
      n_err++;
      $display("FAIL same_set_wins: got haz=%b, expected 1", chk_hazard);
    end
    adv();
    mdu_valid = 0;
    #1;
    n_checks++;
    if ({regwrite, waddr, wdata, chk_hazard} !== {1'b1, 5'd7, 32'h7777_0002, !BYP}) begin
      n_err++;
      $display("FAIL same_drain: got rw=%b wa=%0d wd=%h haz=%b, expected 1 7 77770002 %b",
               regwrite, waddr, wdata, chk_hazard, !BYP);
    end
    adv();
    #1;
    n_checks++;
    if (chk_hazard !== 1'b0) begin
      n_err++;
      $display("FAIL same_clear: got haz=%b, expected 0", chk_hazard);
    end
    adv();
  endtask

  task automatic test_x0();
    drive_idle();
    pipe_we = 1; pipe_waddr = 0; pipe_wdata = 32'hFFFF;
    iss_valid = 1; iss_rd = 0; mdu_valid = 1; mdu_waddr = 0; mdu_wdata = 32'h1234;
    #1;
    n_checks++;
    if ({regwrite, mdu_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL x0_cycle: got rw=%b rdy=%b, expected rw=0 rdy=1", regwrite, mdu_ready);
    end
    adv();
    drive_idle();
    #1;
    n_checks++;
    if ({regwrite, chk_hazard, fifo_count} !== {2'b00, CW'(0)}) begin
      n_err++;
      $display("FAIL x0_after: got rw=%b haz=%b cnt=%0d, expected 0 0 0", regwrite, chk_hazard, fifo_count);
    end
    adv();
  endtask

  task automatic test_reset_mid();
    drive_idle(); pipe_we = 1; pipe_waddr = 3; pipe_wdata = 32'h3;
    for (int i = 0; i < 3; i++) begin
      mdu_valid = 1; mdu_waddr = 5'(20 + i); mdu_wdata = 32'(i);
      iss_valid = 1; iss_rd = 5'(20 + i);
      adv();
    end
    mdu_valid = 0; iss_valid = 0; chk_rs1 = 21;
    #1;
    n_checks++;
    if ({fifo_count, chk_hazard} !== {CW'(3), 1'b1}) begin
      n_err++;
      $display("FAIL rmid_before: got cnt=%0d haz=%b, expected cnt=3 haz=1", fifo_count, chk_hazard);
    end
    adv();
    rst = 1; mdu_valid = 1; mdu_waddr = 23; iss_valid = 1; iss_rd = 24; chk_rs2 = 24;
    #1;
    n_checks++;
    if ({regwrite, mdu_ready, pipe_stall, chk_hazard} !== 4'b0000) begin
      n_err++;
      $display("FAIL rmid_during: got rw=%b rdy=%b stall=%b haz=%b, expected all 0",
               regwrite, mdu_ready, pipe_stall, chk_hazard);
    end
    adv();
    rst = 0; drive_idle(); chk_rs1 = 21; chk_rs2 = 24; chk_rd = 20;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_checks++;
      if ({fifo_count, chk_hazard, regwrite} !== {CW'(0), 2'b00}) begin
        n_err++;
        $display("FAIL rmid_after[%0d]: got cnt=%0d haz=%b rw=%b, expected 0 0 0",
                 k, fifo_count, chk_hazard, regwrite);
      end
      adv();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rst        = ($urandom_range(0, 99) == 0);
      pipe_we    = (c < 300) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 9) < 3);
      pipe_waddr = 5'($urandom_range(0, 31));
      pipe_wdata = $urandom;
      mdu_valid  = $urandom_range(0, 1) == 1;
      mdu_waddr  = 5'($urandom_range(0, 31));
      mdu_wdata  = $urandom;
      iss_rd     = 5'($urandom_range(0, 31));
      iss_valid  = ($urandom_range(0, 2) == 0) && !m_busy[iss_rd];
      chk_rs1    = 5'($urandom_range(0, 31));
      chk_rs2    = 5'($urandom_range(0, 31));
      chk_rd     = 5'($urandom_range(0, 31));
      #1;
      model_comb();
      n_checks++;
      if ({regwrite, waddr, wdata, mdu_ready, pipe_stall, chk_hazard, fifo_count} !==
          {exp_rw, exp_wa, exp_wd, exp_ready, exp_stall, exp_haz, exp_cnt}) begin
        n_err++;
        $display("FAIL random[%0d]: got rw=%b wa=%0d wd=%h rdy=%b stall=%b haz=%b cnt=%0d, expected rw=%b wa=%0d wd=%h rdy=%b stall=%b haz=%b cnt=%0d",
                 c, regwrite, waddr, wdata, mdu_ready, pipe_stall, chk_hazard, fifo_count,
                 exp_rw, exp_wa, exp_wd, exp_ready, exp_stall, exp_haz, exp_cnt);
      end
      adv();
    end
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    m_busy = '0;
    m_wait = 0;
    test_reset();
    test_basic_drain();
    test_priority();
    test_starvation();
    test_full();
    test_same_reg();
    test_x0();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
